// File: rtl/wb_gain_ctrl.sv
// Grey-world white-balance gain controller: once per frame, divides the mean of the
// three channel sums by each channel sum on one shared restoring divider.
module wb_gain_ctrl #(
    parameter int SUM_W  = 28,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             en,
    input  logic [SUM_W-1:0] r_sum,
    input  logic [SUM_W-1:0] g_sum,
    input  logic [SUM_W-1:0] b_sum,
    output logic [15:0]      gain_r,
    output logic [15:0]      gain_g,
    output logic [15:0]      gain_b,
    output logic             gain_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int D_W   = SUM_W + 2;
    localparam int N_W   = D_W + FRAC_W;
    localparam int CNT_W = $clog2(N_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);
    localparam logic [15:0]      UNITY     = 16'(1 << FRAC_W);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DIV,
        PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } ch_t;

    state_t            state;
    ch_t               ch;
    logic              vsync_d;
    logic              primed;
    logic [SUM_W-1:0]  r_snap;
    logic [SUM_W-1:0]  g_snap;
    logic [SUM_W-1:0]  b_snap;
    logic [N_W-1:0]    n_reg;
    logic [D_W-1:0]    d_reg;
    logic [D_W-1:0]    rem;
    logic [CNT_W-1:0]  iter;
    logic [15:0]       stage_r;
    logic [15:0]       stage_g;
    logic [15:0]       stage_b;

    logic              frame_edge;
    logic [D_W-1:0]    snap_total;
    logic [SUM_W-1:0]  snap_sel;
    logic [D_W:0]      div_trial;
    logic              div_ge;
    logic [D_W-1:0]    rem_diff;
    logic [D_W-1:0]    rem_next;
    logic [N_W-1:0]    q_next;
    logic [15:0]       stage_val;

    // vsync_d is cleared by reset, so the first edge after release would otherwise
    // look like a rising vsync; primed masks that one edge.
    assign frame_edge = vsync & ~vsync_d & primed;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        snap_total = D_W'(r_snap) + D_W'(g_snap) + D_W'(b_snap);
        snap_sel   = r_snap;
        case (ch)
            CH_G:    snap_sel = g_snap;
            CH_B:    snap_sel = b_snap;
            default: snap_sel = r_snap;
        endcase

        // Quotient bits shift into the dividend register's LSB as it empties from the MSB.
        div_trial = {rem, n_reg[N_W-1]};
        div_ge    = (div_trial >= {1'b0, d_reg});
        rem_diff  = div_trial[D_W-1:0] - d_reg;
        rem_next  = div_ge ? rem_diff : div_trial[D_W-1:0];
        q_next    = {n_reg[N_W-2:0], div_ge};

        if (snap_sel == '0)
            stage_val = (snap_total == '0) ? UNITY : 16'hFFFF;
        else if (|q_next[N_W-1:16])
            stage_val = 16'hFFFF;
        else
            stage_val = q_next[15:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= CH_R;
            vsync_d    <= 1'b0;
            primed     <= 1'b0;
            r_snap     <= '0;
            g_snap     <= '0;
            b_snap     <= '0;
            n_reg      <= '0;
            d_reg      <= '0;
            rem        <= '0;
            iter       <= '0;
            stage_r    <= '0;
            stage_g    <= '0;
            stage_b    <= '0;
            gain_r     <= UNITY;
            gain_g     <= UNITY;
            gain_b     <= UNITY;
            gain_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            primed     <= 1'b1;
            gain_valid <= 1'b0;
            overrun    <= frame_edge && (state != IDLE);

            case (state)
                IDLE: begin
                    if (frame_edge && en) begin
                        r_snap <= r_sum;
                        g_snap <= g_sum;
                        b_snap <= b_sum;
                        ch     <= CH_R;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end

                SETUP: begin
                    n_reg <= {snap_total, FRAC_W'(0)};
                    d_reg <= D_W'(snap_sel) + D_W'({snap_sel, 1'b0});
                    rem   <= '0;
                    iter  <= '0;
                    state <= DIV;
                end

                DIV: begin
                    n_reg <= q_next;
                    rem   <= rem_next;
                    iter  <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        case (ch)
                            CH_R: begin
                                stage_r <= stage_val;
                                ch      <= CH_G;
                                state   <= SETUP;
                            end
                            CH_G: begin
                                stage_g <= stage_val;
                                ch      <= CH_B;
                                state   <= SETUP;
                            end
                            default: begin
                                stage_b <= stage_val;
                                state   <= PUBLISH;
                            end
                        endcase
                    end
                end

                PUBLISH: begin
                    gain_r     <= stage_r;
                    gain_g     <= stage_g;
                    gain_b     <= stage_b;
                    gain_valid <= 1'b1;
                    busy       <= 1'b0;
                    ch         <= CH_R;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_gain_ctrl.sv
// Directed bench for wb_gain_ctrl: latency, gain values, zero/saturation, overrun,
// enable gating and reset behaviour against hand-computed expectations.
module tb_wb_gain_ctrl;

    localparam int SUM_W = 28;
    localparam int LAT   = 118;

    logic             clk = 1'b0;
    logic             rst;
    logic             vsync;
    logic             en;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] g_sum;
    logic [SUM_W-1:0] b_sum;
    logic [15:0]      gain_r;
    logic [15:0]      gain_g;
    logic [15:0]      gain_b;
    logic             gain_valid;
    logic             busy;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    wb_gain_ctrl #(.SUM_W(SUM_W), .FRAC_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .en         (en),
        .r_sum      (r_sum),
        .g_sum      (g_sum),
        .b_sum      (b_sum),
        .gain_r     (gain_r),
        .gain_g     (gain_g),
        .gain_b     (gain_b),
        .gain_valid (gain_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gains(input string tag, input logic [15:0] er, input logic [15:0] eg,
                               input logic [15:0] eb);
        check({tag, "_r"}, 32'(gain_r), 32'(er));
        check({tag, "_g"}, 32'(gain_g), 32'(eg));
        check({tag, "_b"}, 32'(gain_b), 32'(eb));
    endtask

    // Presents sums with a vsync rise; returns after the edge that samples it.
    task automatic start_frame(input logic [SUM_W-1:0] r, input logic [SUM_W-1:0] g,
                               input logic [SUM_W-1:0] b);
        r_sum = r;
        g_sum = g;
        b_sum = b;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    // Counts edges after the sampling edge until gain_valid; second vsync rise at edge 'at'.
    task automatic run_to_valid(input int at, output int lat, output int ov_cnt, output int ov_at);
        lat    = 999;
        ov_cnt = 0;
        ov_at  = -1;
        for (int i = 1; i <= 300; i++) begin
            vsync = (i == at);
            tick();
            if (overrun) begin
                ov_cnt++;
                ov_at = i;
            end
            if (gain_valid) begin
                lat = i;
                break;
            end
        end
        vsync = 1'b0;
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (gain_valid) n++;
        end
    endtask

    task automatic frame_case(input string tag, input logic [SUM_W-1:0] r,
                              input logic [SUM_W-1:0] g, input logic [SUM_W-1:0] b,
                              input logic [15:0] er, input logic [15:0] eg,
                              input logic [15:0] eb);
        int lat, ov_cnt, ov_at;
        start_frame(r, g, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        run_to_valid(0, lat, ov_cnt, ov_at);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check_gains(tag, er, eg, eb);
        tick();
        check({tag, "_pulse"}, 32'(gain_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, ov_cnt, ov_at, n;

        rst   = 1'b1;
        vsync = 1'b0;
        en    = 1'b0;
        r_sum = '0;
        g_sum = '0;
        b_sum = '0;
        repeat (3) tick();
        check_gains("reset", 16'h0100, 16'h0100, 16'h0100);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(gain_valid), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        en = 1'b1;

        frame_case("balanced", 28'h0100000, 28'h0100000, 28'h0100000, 16'h0100, 16'h0100, 16'h0100);
        frame_case("unbal", 28'h0100000, 28'h0200000, 28'h0300000, 16'h0200, 16'h0100, 16'h00AA);
        frame_case("zero_r", 28'h0, 28'h100, 28'h100, 16'hFFFF, 16'h00AA, 16'h00AA);
        frame_case("all_zero", 28'h0, 28'h0, 28'h0, 16'h0100, 16'h0100, 16'h0100);
        frame_case("sat", 28'h1, 28'h1000000, 28'h1000000, 16'hFFFF, 16'h00AA, 16'h00AA);

        // Enable gating: new sums with en low must not start anything.
        en = 1'b0;
        start_frame(28'h0100000, 28'h0200000, 28'h0300000);
        check("gated_busy", 32'(busy), 32'd0);
        count_valid(150, n);
        check("gated_valid", 32'(n), 32'd0);
        check_gains("gated", 16'hFFFF, 16'h00AA, 16'h00AA);
        en = 1'b1;

        // Second rise 50 edges in, with inputs changed mid-computation.
        start_frame(28'h0100000, 28'h0200000, 28'h0300000);
        r_sum = 28'h0100000;
        g_sum = 28'h0100000;
        b_sum = 28'h0100000;
        run_to_valid(50, lat, ov_cnt, ov_at);
        check("ovr_at", 32'(ov_at), 32'd50);
        check("ovr_cnt", 32'(ov_cnt), 32'd1);
        check("ovr_lat", 32'(lat), 32'(LAT));
        check_gains("ovr", 16'h0200, 16'h0100, 16'h00AA);
        count_valid(150, n);
        check("ovr_dropped", 32'(n), 32'd0);

        // A rise on the PUBLISH edge is an overrun too.
        start_frame(28'h0, 28'h100, 28'h100);
        run_to_valid(LAT, lat, ov_cnt, ov_at);
        check("pub_ovr_at", 32'(ov_at), 32'(LAT));
        check("pub_lat", 32'(lat), 32'(LAT));
        check_gains("pub", 16'hFFFF, 16'h00AA, 16'h00AA);
        count_valid(150, n);
        check("pub_dropped", 32'(n), 32'd0);

        // Reset at cycle 60 of a computation.
        start_frame(28'h0100000, 28'h0200000, 28'h0300000);
        repeat (59) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check_gains("rst_mid", 16'h0100, 16'h0100, 16'h0100);
        tick();
        rst = 1'b0;
        count_valid(150, n);
        check("rst_mid_valid", 32'(n), 32'd0);
        check_gains("rst_after", 16'h0100, 16'h0100, 16'h0100);
        frame_case("rst_next", 28'h0100000, 28'h0200000, 28'h0300000, 16'h0200, 16'h0100, 16'h00AA);

        // vsync already high as reset releases: no frame edge.
        rst   = 1'b1;
        vsync = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rel_high_busy", 32'(busy), 32'd0);
        tick();
        check("rel_high_busy2", 32'(busy), 32'd0);
        vsync = 1'b0;
        tick();
        frame_case("rel_next", 28'h100, 28'h100, 28'h0, 16'h00AA, 16'h00AA, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
